// File: rtl/desnorm_seq_pkg.sv
// Shared types and defaults for the I/V converter pair sequencer.
package desnorm_seq_pkg;

  localparam int unsigned DEF_W           = 32;
  localparam int unsigned DEF_TIMEOUT_CYC = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_START,
    ST_WAIT,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/result_capture_reg.sv
// First-ACK result latch: keeps the value seen on the first ACK cycle of a
// pair and ignores later ACKs until cleared.
module result_capture_reg
  import desnorm_seq_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         ack,
  input  logic [W-1:0] res,
  output logic [W-1:0] data,
  output logic         flag
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      flag <= 1'b0;
    end else if (clr) begin
      data <= '0;
      flag <= 1'b0;
    end else if (en && ack && !flag) begin
      data <= res;
      flag <= 1'b1;
    end
  end

endmodule

// File: rtl/desnorm_pair_sequencer.sv
// Sequences one I/V sample pair through the fixed-to-float converter pair
// and returns both results together, with a timeout abort.
module desnorm_pair_sequencer
  import desnorm_seq_pkg::*;
#(
  parameter int unsigned W           = DEF_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] i_fix,
  input  logic [W-1:0] v_fix,
  output logic [W-1:0] i_out,
  output logic [W-1:0] v_out,
  output logic         rst_conv,
  output logic         begin_i,
  output logic         begin_v,
  input  logic         ack_i,
  input  logic         ack_v,
  input  logic [W-1:0] res_i,
  input  logic [W-1:0] res_v,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_i,
  output logic [W-1:0] out_v,
  output logic         out_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);

  seq_state_e    state;
  logic [CW-1:0] cnt;
  logic          flag_i;
  logic          flag_v;
  logic          in_wait;
  logic          in_clear;
  logic          both_c;

  assign in_wait  = (state == ST_WAIT);
  assign in_clear = (state == ST_CLEAR);
  // Completion counts an ACK arriving this cycle, so it beats the timeout.
  assign both_c   = (flag_i | ack_i) & (flag_v | ack_v);

  result_capture_reg #(.W(W)) u_cap_i (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (in_clear),
    .en   (in_wait),
    .ack  (ack_i),
    .res  (res_i),
    .data (out_i),
    .flag (flag_i)
  );

  result_capture_reg #(.W(W)) u_cap_v (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (in_clear),
    .en   (in_wait),
    .ack  (ack_v),
    .res  (res_v),
    .data (out_v),
    .flag (flag_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rst_conv  <= 1'b1;
      in_ready  <= 1'b0;
      begin_i   <= 1'b0;
      begin_v   <= 1'b0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      i_out     <= '0;
      v_out     <= '0;
      cnt       <= '0;
    end else begin
      rst_conv <= 1'b0;
      begin_i  <= 1'b0;
      begin_v  <= 1'b0;
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            i_out    <= i_fix;
            v_out    <= v_fix;
            in_ready <= 1'b0;
            rst_conv <= 1'b1;
            state    <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          cnt     <= '0;
          out_err <= 1'b0;
          begin_i <= 1'b1;
          begin_v <= 1'b1;
          state   <= ST_START;
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
          if (both_c) begin
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            out_valid <= 1'b1;
            out_err   <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
